// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle Moore controller for the stored-program CPU datapath, PC, IR and data memory.
// Ports: clk/reset (sync, active-high); opcode/op from the instruction decoder; nsel/vsel/load*/asel/bsel/write
// drive the register-file/ALU datapath; load_ir, load_pc/reset_pc, addr_sel/load_addr/mem_cmd drive fetch and
// memory; halted flags the HALT state. MEM_WAIT adds wait cycles to each memory-read state.
module cpu_sequencer #(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       halted
);
  typedef enum logic [4:0] {
    RST, IF1, IF2, UPDATE_PC, DECODE, WR_IMM, GET_A, GET_B, GET_B_CMP, CALC,
    WR_REG, CMP_S, CALC_ADDR, LOAD_ADDR, MEM_RD, WR_MEM, GET_RD, PASS_B, MEM_WR, HALT
  } state_t;
  localparam logic [3:0] MW = 4'(MEM_WAIT);
  localparam logic [4:0] I_MOVI = 5'b110_10, I_MOVS = 5'b110_00, I_ADD = 5'b101_00, I_CMP = 5'b101_01;
  localparam logic [4:0] I_AND = 5'b101_10, I_MVN = 5'b101_11, I_LDR = 5'b011_00, I_STR = 5'b100_00;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] ins;
  assign ins = {opcode, op};
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // Counter only advances inside a memory-read state; any other state holds it at zero,
  // so it is already cleared on entry to IF1/MEM_RD.
  always_comb begin
    cnt_d = ((state_q == IF1 || state_q == MEM_RD) && cnt_q != MW) ? cnt_q + 4'd1 : 4'd0;
    state_d = state_q;
    case (state_q)
      RST:       state_d = IF1;
      IF1:       state_d = (cnt_q == MW) ? IF2 : IF1;
      IF2:       state_d = UPDATE_PC;
      UPDATE_PC: state_d = DECODE;
      DECODE:
        case (ins)
          I_MOVI:                state_d = WR_IMM;
          I_MOVS, I_MVN:         state_d = GET_B;
          I_ADD, I_CMP, I_AND,
          I_LDR, I_STR:          state_d = GET_A;
          default:               state_d = HALT;
        endcase
      GET_A:     state_d = (ins == I_CMP) ? GET_B_CMP : (ins == I_LDR || ins == I_STR) ? CALC_ADDR : GET_B;
      GET_B:     state_d = CALC;
      GET_B_CMP: state_d = CMP_S;
      CALC:      state_d = WR_REG;
      WR_IMM, WR_REG, CMP_S, WR_MEM, MEM_WR: state_d = IF1;
      CALC_ADDR: state_d = LOAD_ADDR;
      LOAD_ADDR: state_d = (ins == I_LDR) ? MEM_RD : GET_RD;
      MEM_RD:    state_d = (cnt_q == MW) ? WR_MEM : MEM_RD;
      GET_RD:    state_d = PASS_B;
      PASS_B:    state_d = MEM_WR;
      HALT:      state_d = HALT;
      default:   state_d = RST;
    endcase
  end
  always_comb begin
    nsel = 3'b000;
    vsel = 4'b0000;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel = 1'b0;
    bsel = 1'b0;
    write = 1'b0;
    load_ir = 1'b0;
    load_pc = 1'b0;
    reset_pc = 1'b0;
    addr_sel = 1'b0;
    load_addr = 1'b0;
    mem_cmd = 2'b00;
    halted = 1'b0;
    case (state_q)
      RST:       begin reset_pc = 1'b1; load_pc = 1'b1; end
      IF1:       begin addr_sel = 1'b1; mem_cmd = 2'b01; end
      IF2:       begin addr_sel = 1'b1; mem_cmd = 2'b01; load_ir = 1'b1; end
      UPDATE_PC: load_pc = 1'b1;
      WR_IMM:    begin nsel = 3'b001; vsel = 4'b0100; write = 1'b1; end
      GET_A:     begin nsel = 3'b001; loada = 1'b1; end
      GET_B, GET_B_CMP: begin nsel = 3'b100; loadb = 1'b1; end
      // MOV shift and MVN operate on B alone, so A is forced to zero.
      CALC:      begin loadc = 1'b1; asel = (ins == I_MOVS || ins == I_MVN); end
      WR_REG:    begin nsel = 3'b010; vsel = 4'b0001; write = 1'b1; end
      CMP_S:     loads = 1'b1;
      CALC_ADDR: begin bsel = 1'b1; loadc = 1'b1; end
      LOAD_ADDR: load_addr = 1'b1;
      MEM_RD:    mem_cmd = 2'b01;
      WR_MEM:    begin mem_cmd = 2'b01; nsel = 3'b010; vsel = 4'b1000; write = 1'b1; end
      GET_RD:    begin nsel = 3'b010; loadb = 1'b1; end
      PASS_B:    begin asel = 1'b1; loadc = 1'b1; end
      MEM_WR:    mem_cmd = 2'b10;
      HALT:      halted = 1'b1;
      default:   ;
    endcase
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed per-cycle trace checks of cpu_sequencer control outputs.
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic [2:0] nsel [2];
  logic [3:0] vsel [2];
  logic [1:0] mem_cmd [2];
  logic loada [2], loadb [2], loadc [2], loads [2], asel [2], bsel [2], write [2];
  logic load_ir [2], load_pc [2], reset_pc [2], addr_sel [2], load_addr [2], halted [2];
  int n_run = 0;
  int n_fail = 0;
  logic [21:0] exp_q [$];
  always #5 clk = ~clk;
  cpu_sequencer #(.MEM_WAIT(0)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .nsel(nsel[0]), .vsel(vsel[0]),
    .loada(loada[0]), .loadb(loadb[0]), .loadc(loadc[0]), .loads(loads[0]), .asel(asel[0]),
    .bsel(bsel[0]), .write(write[0]), .load_ir(load_ir[0]), .load_pc(load_pc[0]),
    .reset_pc(reset_pc[0]), .addr_sel(addr_sel[0]), .load_addr(load_addr[0]),
    .mem_cmd(mem_cmd[0]), .halted(halted[0])
  );
  cpu_sequencer #(.MEM_WAIT(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .nsel(nsel[1]), .vsel(vsel[1]),
    .loada(loada[1]), .loadb(loadb[1]), .loadc(loadc[1]), .loads(loads[1]), .asel(asel[1]),
    .bsel(bsel[1]), .write(write[1]), .load_ir(load_ir[1]), .load_pc(load_pc[1]),
    .reset_pc(reset_pc[1]), .addr_sel(addr_sel[1]), .load_addr(load_addr[1]),
    .mem_cmd(mem_cmd[1]), .halted(halted[1])
  );
  // Bit layout: nsel[21:19] vsel[18:15] loada loadb loadc loads asel bsel write load_ir load_pc reset_pc
  // addr_sel load_addr [14:3], mem_cmd[2:1], halted[0].
  localparam logic [21:0] N_RN = 22'h1 << 19, N_RD = 22'h2 << 19, N_RM = 22'h4 << 19;
  localparam logic [21:0] V_MD = 22'h8 << 15, V_IM = 22'h4 << 15, V_C = 22'h1 << 15;
  localparam logic [21:0] LA = 22'h1 << 14, LB = 22'h1 << 13, LC = 22'h1 << 12, LS = 22'h1 << 11;
  localparam logic [21:0] AS = 22'h1 << 10, BS = 22'h1 << 9, WR = 22'h1 << 8, IR = 22'h1 << 7;
  localparam logic [21:0] PC = 22'h1 << 6, RPC = 22'h1 << 5, AD = 22'h1 << 4, LAD = 22'h1 << 3;
  localparam logic [21:0] RD = 22'h1 << 1, WT = 22'h2 << 1, H = 22'h1;
  localparam logic [21:0] S_RST = PC | RPC, S_IF1 = AD | RD, S_IF2 = AD | RD | IR, S_UPC = PC, S_DEC = 22'h0;
  localparam logic [21:0] S_WIMM = N_RN | V_IM | WR, S_GA = N_RN | LA, S_GB = N_RM | LB;
  localparam logic [21:0] S_CALC0 = LC, S_CALC1 = LC | AS, S_WREG = N_RD | V_C | WR, S_CMPS = LS;
  localparam logic [21:0] S_CADR = BS | LC, S_LADR = LAD, S_MRD = RD, S_WMEM = RD | N_RD | V_MD | WR;
  localparam logic [21:0] S_GRD = N_RD | LB, S_PASS = AS | LC, S_MWR = WT, S_HALT = H;
  function automatic logic [21:0] ctrl(input int s);
    return {nsel[s], vsel[s], loada[s], loadb[s], loadc[s], loads[s], asel[s], bsel[s], write[s],
            load_ir[s], load_pc[s], reset_pc[s], addr_sel[s], load_addr[s], mem_cmd[s], halted[s]};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [2:0] opc, input logic [1:0] o);
    opcode = opc;
    op = o;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  // Compares one sample per cycle, first sample taken at the current negedge (the RST cycle).
  task automatic run_trace(input string tag, input int s);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), 32'(ctrl(s)), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask
  initial begin
    start(3'b110, 2'b10);
    exp_q = '{S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM, S_IF1};
    run_trace("movi", 0);
    start(3'b110, 2'b00);
    exp_q = '{S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_GB, S_CALC1, S_WREG, S_IF1};
    run_trace("movs", 0);
    start(3'b101, 2'b00);
    exp_q = '{S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_GA, S_GB, S_CALC0, S_WREG, S_IF1, S_IF2};
    run_trace("add", 0);
    start(3'b101, 2'b10);
    exp_q = '{S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_GA, S_GB, S_CALC0, S_WREG, S_IF1};
    run_trace("and", 0);
    start(3'b101, 2'b11);
    exp_q = '{S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_GB, S_CALC1, S_WREG, S_IF1};
    run_trace("mvn", 0);
    start(3'b101, 2'b01);
    exp_q = '{S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_GA, S_GB, S_CMPS, S_IF1, S_IF2};
    run_trace("cmp", 0);
    start(3'b100, 2'b00);
    exp_q = '{S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_GA, S_CADR, S_LADR, S_GRD, S_PASS, S_MWR, S_IF1};
    run_trace("str", 0);
    start(3'b011, 2'b00);
    exp_q = '{S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_GA, S_CADR, S_LADR, S_MRD, S_WMEM, S_IF1};
    run_trace("ldr", 0);
    start(3'b011, 2'b00);
    exp_q = '{S_RST, S_IF1, S_IF1, S_IF1, S_IF2, S_UPC, S_DEC, S_GA, S_CADR, S_LADR,
              S_MRD, S_MRD, S_MRD, S_WMEM, S_IF1, S_IF1, S_IF1, S_IF2};
    run_trace("ldr_w2", 1);
    start(3'b111, 2'b01);
    exp_q = '{S_RST, S_IF1, S_IF2, S_UPC, S_DEC};
    for (int i = 0; i < 20; i++) exp_q.push_back(S_HALT);
    run_trace("halt", 0);
    start(3'b001, 2'b00);
    exp_q = '{S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_HALT, S_HALT};
    run_trace("illegal001", 0);
    start(3'b110, 2'b01);
    exp_q = '{S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_HALT, S_HALT};
    run_trace("illegal110_01", 0);
    start(3'b100, 2'b00);
    exp_q = '{S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_GA, S_CADR, S_LADR, S_GRD, S_PASS, S_MWR};
    run_trace("str_abort", 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_rst", 32'(ctrl(0)), 32'(S_RST));
    @(negedge clk);
    check("abort_if1", 32'(ctrl(0)), 32'(S_IF1));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
